rv32imf_writeback_stage: RTL

RV32IMF_WRITEBACK_STAGE -- requirements
Module: rv32imf_writeback_stage

---
 rtl/rv32imf_writeback_stage.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/rv32imf_writeback_stage.sv
// rtl/rv32imf_writeback_stage.sv - RV32IMF writeback: registered ALU port A, LSU/FPU-FIFO port B, optional scoreboard (RV32IMF_WB_SCOREBOARD_EN)
module rv32imf_writeback_stage #(
    parameter int ADDR_WIDTH = 6,
    parameter int DATA_WIDTH = 32,
    parameter int FIFO_DEPTH = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  ex_valid_i,
    input  logic [ADDR_WIDTH-1:0] ex_addr_i,
    input  logic [DATA_WIDTH-1:0] ex_data_i,
    input  logic                  lsu_valid_i,
    input  logic [ADDR_WIDTH-1:0] lsu_addr_i,
    input  logic [DATA_WIDTH-1:0] lsu_data_i,
    input  logic                  fpu_valid_i,
    output logic                  fpu_ready_o,
    input  logic [ADDR_WIDTH-1:0] fpu_addr_i,
    input  logic [DATA_WIDTH-1:0] fpu_data_i,
    output logic                  we_a_o,
    output logic [ADDR_WIDTH-1:0] waddr_a_o,
    output logic [DATA_WIDTH-1:0] wdata_a_o,
    output logic                  we_b_o,
    output logic [ADDR_WIDTH-1:0] waddr_b_o,
    output logic [DATA_WIDTH-1:0] wdata_b_o,
    output logic [2:0]            fifo_cnt_o,
    input  logic                  issue_valid_i,
    input  logic [ADDR_WIDTH-1:0] issue_addr_i,
    input  logic [ADDR_WIDTH-1:0] raddr_a_i,
    input  logic [ADDR_WIDTH-1:0] raddr_b_i,
    input  logic [ADDR_WIDTH-1:0] raddr_c_i,
    output logic                  hazard_a_o,
    output logic                  hazard_b_o,
    output logic                  hazard_c_o
);

    localparam int PW = (FIFO_DEPTH > 2) ? 2 : 1;
    localparam int EW = ADDR_WIDTH + DATA_WIDTH;

    logic                  we_a_q, we_a_d, we_b_q, we_b_d;
    logic [ADDR_WIDTH-1:0] waddr_a_q, waddr_a_d, waddr_b_q, waddr_b_d;
    logic [DATA_WIDTH-1:0] wdata_a_q, wdata_a_d, wdata_b_q, wdata_b_d;
    logic [2:0]            cnt_q, cnt_d;
    logic [PW-1:0]         rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [EW-1:0]         mem_q [FIFO_DEPTH];
    logic [EW-1:0]         mem_d [FIFO_DEPTH];
    logic [EW-1:0]         head;
    logic                  push, pop;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // FPU result buffer: ready depends only on the registered count; LSU always has priority for port B
    always_comb begin
        fpu_ready_o = (cnt_q < 3'(FIFO_DEPTH));
        push        = fpu_valid_i && fpu_ready_o;
        pop         = !lsu_valid_i && (cnt_q != 3'd0);
        head        = mem_q[rd_ptr_q];
        mem_d       = mem_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        cnt_d       = cnt_q;
        if (push) begin
            mem_d[wr_ptr_q] = {fpu_addr_i, fpu_data_i};
            wr_ptr_d        = ptr_inc(wr_ptr_q);
        end
        if (pop) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end
        case ({push, pop})
            2'b10:   cnt_d = cnt_q + 3'd1;
            2'b01:   cnt_d = cnt_q - 3'd1;
            default: cnt_d = cnt_q;
        endcase
    end

    // Next values of both write ports; x0 writes are suppressed but still consume their source
    always_comb begin
        we_a_d    = ex_valid_i && (ex_addr_i != '0);
        waddr_a_d = ex_addr_i;
        wdata_a_d = ex_data_i;
        we_b_d    = 1'b0;
        waddr_b_d = '0;
        wdata_b_d = '0;
        if (lsu_valid_i) begin
            we_b_d    = (lsu_addr_i != '0);
            waddr_b_d = lsu_addr_i;
            wdata_b_d = lsu_data_i;
        end else if (pop) begin
            we_b_d    = (head[EW-1:DATA_WIDTH] != '0);
            waddr_b_d = head[EW-1:DATA_WIDTH];
            wdata_b_d = head[DATA_WIDTH-1:0];
        end
    end

    // Port registers and FIFO control state
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            we_a_q    <= 1'b0;
            waddr_a_q <= '0;
            wdata_a_q <= '0;
            we_b_q    <= 1'b0;
            waddr_b_q <= '0;
            wdata_b_q <= '0;
            cnt_q     <= '0;
            rd_ptr_q  <= '0;
            wr_ptr_q  <= '0;
        end else begin
            we_a_q    <= we_a_d;
            waddr_a_q <= waddr_a_d;
            wdata_a_q <= wdata_a_d;
            we_b_q    <= we_b_d;
            waddr_b_q <= waddr_b_d;
            wdata_b_q <= wdata_b_d;
            cnt_q     <= cnt_d;
            rd_ptr_q  <= rd_ptr_d;
            wr_ptr_q  <= wr_ptr_d;
        end
    end

    // Buffer storage needs no reset: occupancy is tracked by cnt_q alone
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign we_a_o     = we_a_q;
    assign waddr_a_o  = waddr_a_q;
    assign wdata_a_o  = wdata_a_q;
    assign we_b_o     = we_b_q;
    assign waddr_b_o  = waddr_b_q;
    assign wdata_b_o  = wdata_b_q;
    assign fifo_cnt_o = cnt_q;

`ifdef RV32IMF_WB_SCOREBOARD_EN
    logic [(1<<ADDR_WIDTH)-1:0] pend_q, pend_d;
    logic                       b_fifo_q, b_fifo_d;

    // Pending bits clear one cycle after the buffered write shows on port B; a same-cycle issue wins
    always_comb begin
        b_fifo_d = pop;
        pend_d   = pend_q;
        if (b_fifo_q) begin
            pend_d[waddr_b_q] = 1'b0;
        end
        if (issue_valid_i && (issue_addr_i != '0)) begin
            pend_d[issue_addr_i] = 1'b1;
        end
    end

    // Scoreboard state
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pend_q   <= '0;
            b_fifo_q <= 1'b0;
        end else begin
            pend_q   <= pend_d;
            b_fifo_q <= b_fifo_d;
        end
    end

    assign hazard_a_o = pend_q[raddr_a_i];
    assign hazard_b_o = pend_q[raddr_b_i];
    assign hazard_c_o = pend_q[raddr_c_i];
`else
    logic unused_sb;
    assign unused_sb  = ^{issue_valid_i, issue_addr_i, raddr_a_i, raddr_b_i, raddr_c_i};
    assign hazard_a_o = 1'b0;
    assign hazard_b_o = 1'b0;
    assign hazard_c_o = 1'b0;
`endif

endmodule
